// File: rtl/router_pkt_src.sv
// Store-and-forward packet source for the router: buffers a payload, then emits header, payload and parity.
// Optional macro PKT_SRC_PARITY_ERR_INJ_EN adds inj_err to corrupt bit 0 of the parity byte.
module router_pkt_src #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  input  logic       busy,
`ifdef PKT_SRC_PARITY_ERR_INJ_EN
  input  logic       inj_err,
`endif
  output logic       ready,
  output logic       pl_ready,
  output logic       pkt_valid,
  output logic [7:0] pkt_data,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {IDLE, LOAD, HDR, PLD, PAR, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state_reg;
  logic [5:0] cnt_reg;
  logic [5:0] idx_reg;
  logic [5:0] len_reg;
  logic [3:0] gap_cnt_reg;
  logic [7:0] header_reg;
  logic [7:0] parity_reg;
  logic [7:0] hold_data_reg;
  logic       ready_reg;
  logic       pl_ready_reg;
  logic       pkt_valid_reg;
  logic       done_reg;
  logic       cfg_err_reg;
  logic [7:0] par_out;

  logic [7:0] buf_mem [0:63];
  logic [7:0] rd_data_reg;
  logic [5:0] rd_addr;

`ifdef PKT_SRC_PARITY_ERR_INJ_EN
  logic inj_reg;
  assign par_out = parity_reg ^ {7'd0, inj_reg};
`else
  assign par_out = parity_reg;
`endif

  // Pre-fetch the byte that will be on the bus after the coming edge.
  always_comb begin
    rd_addr = 6'd0;
    if (state_reg == PLD)
      rd_addr = busy ? idx_reg : idx_reg + 6'd1;
  end

  always_ff @(posedge clock) begin
    if (state_reg == LOAD && pl_valid)
      buf_mem[cnt_reg] <= pl_data;
    rd_data_reg <= buf_mem[rd_addr];
  end

  always_ff @(posedge clock) begin
    done_reg    <= 1'b0;
    cfg_err_reg <= 1'b0;
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 6'd0;
      idx_reg       <= 6'd0;
      len_reg       <= 6'd0;
      gap_cnt_reg   <= 4'd0;
      header_reg    <= 8'd0;
      parity_reg    <= 8'd0;
      hold_data_reg <= 8'd0;
      ready_reg     <= 1'b1;
      pl_ready_reg  <= 1'b0;
      pkt_valid_reg <= 1'b0;
`ifdef PKT_SRC_PARITY_ERR_INJ_EN
      inj_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (dest == 2'd3 || len == 6'd0) begin
              cfg_err_reg <= 1'b1;
            end else begin
              header_reg   <= {len, dest};
              parity_reg   <= {len, dest};
              len_reg      <= len;
              cnt_reg      <= 6'd0;
              ready_reg    <= 1'b0;
              pl_ready_reg <= 1'b1;
              state_reg    <= LOAD;
`ifdef PKT_SRC_PARITY_ERR_INJ_EN
              inj_reg      <= inj_err;
`endif
            end
          end
        end
        LOAD: begin
          if (pl_valid) begin
            parity_reg <= parity_reg ^ pl_data;
            cnt_reg    <= cnt_reg + 6'd1;
            if (cnt_reg == len_reg - 6'd1) begin
              pl_ready_reg  <= 1'b0;
              pkt_valid_reg <= 1'b1;
              hold_data_reg <= header_reg;
              state_reg     <= HDR;
            end
          end
        end
        HDR: begin
          if (!busy) begin
            idx_reg   <= 6'd0;
            state_reg <= PLD;
          end
        end
        PLD: begin
          if (!busy) begin
            if (idx_reg == len_reg - 6'd1) begin
              pkt_valid_reg <= 1'b0;
              hold_data_reg <= par_out;
              state_reg     <= PAR;
            end else begin
              idx_reg <= idx_reg + 6'd1;
            end
          end
        end
        PAR: begin
          if (!busy) begin
            hold_data_reg <= 8'd0;
            gap_cnt_reg   <= 4'd0;
            state_reg     <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready     = ready_reg;
  assign pl_ready  = pl_ready_reg;
  assign pkt_valid = pkt_valid_reg;
  assign pkt_data  = (state_reg == PLD) ? rd_data_reg : hold_data_reg;
  assign done      = done_reg;
  assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: normal, illegal-start, busy-stall, max-length and reset-abort packets.
module tb_router_pkt_src;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       busy;
  logic       ready;
  logic       pl_ready;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       done;
  logic       cfg_err;
`ifdef PKT_SRC_PARITY_ERR_INJ_EN
  logic       inj_err = 1'b0;
`endif

  int vectors = 0;
  int errs = 0;
  logic [7:0] pl [0:63];

  router_pkt_src #(.GAP_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .start(start), .dest(dest), .len(len),
    .pl_valid(pl_valid), .pl_data(pl_data), .busy(busy),
`ifdef PKT_SRC_PARITY_ERR_INJ_EN
    .inj_err(inj_err),
`endif
    .ready(ready), .pl_ready(pl_ready), .pkt_valid(pkt_valid),
    .pkt_data(pkt_data), .done(done), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends one packet whose payload is pl[0..l-1]; beat bbeat (0 = header) is stalled bn cycles.
  task automatic run_pkt(input logic [1:0] d, input logic [5:0] l,
                         input logic [7:0] exp_hdr, input logic [7:0] exp_par,
                         input int bbeat, input int bn, input int exp_cycles);
    int cycles;
    logic [7:0] e;
    cycles = 0;
    start = 1'b1; dest = d; len = l;
    tick(); cycles++;
    start = 1'b0;
    chk("load_ready", {7'd0, ready}, 8'd0);
    chk("load_pl_ready", {7'd0, pl_ready}, 8'd1);
    for (int i = 0; i < int'(l); i++) begin
      pl_valid = 1'b1; pl_data = pl[i];
      tick(); cycles++;
    end
    pl_valid = 1'b0;
    for (int b = 0; b <= int'(l); b++) begin
      e = (b == 0) ? exp_hdr : pl[b-1];
      if (b == bbeat) begin
        busy = 1'b1;
        for (int k = 0; k < bn; k++) begin
          chk($sformatf("hold_valid_b%0d", b), {7'd0, pkt_valid}, 8'd1);
          chk($sformatf("hold_data_b%0d", b), pkt_data, e);
          tick(); cycles++;
        end
        busy = 1'b0;
      end
      chk($sformatf("beat_valid_b%0d", b), {7'd0, pkt_valid}, 8'd1);
      chk($sformatf("beat_data_b%0d", b), pkt_data, e);
      tick(); cycles++;
    end
    chk("par_valid", {7'd0, pkt_valid}, 8'd0);
    chk("par_data", pkt_data, exp_par);
    tick(); cycles++;
    for (int g = 0; g < 2; g++) begin
      chk("gap_data", pkt_data, 8'd0);
      chk("gap_done", {7'd0, done}, 8'd0);
      tick(); cycles++;
    end
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("done_ready", {7'd0, ready}, 8'd1);
    chk("start_to_done_cycles", 8'(cycles), 8'(exp_cycles));
    $display("packet dest=%0d len=%0d hdr=%h par=%h cycles=%0d", d, l, exp_hdr, exp_par, cycles);
    tick();
    chk("done_clear", {7'd0, done}, 8'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dest = 2'd0; len = 6'd0;
    pl_valid = 1'b0; pl_data = 8'd0; busy = 1'b0;
    tick(); tick();
    chk("rst_ready", {7'd0, ready}, 8'd1);
    chk("rst_pl_ready", {7'd0, pl_ready}, 8'd0);
    chk("rst_pkt_valid", {7'd0, pkt_valid}, 8'd0);
    chk("rst_pkt_data", pkt_data, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_cfg_err", {7'd0, cfg_err}, 8'd0);
    reset = 1'b0;
    tick();

    // Basic packet: dest=1 len=3.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    run_pkt(2'd1, 6'd3, 8'h0D, 8'h0D, -1, 0, 11);

    // Illegal starts.
    start = 1'b1; dest = 2'd3; len = 6'd5;
    tick();
    start = 1'b0;
    chk("cfg_err_dest3", {7'd0, cfg_err}, 8'd1);
    chk("cfg_err_ready", {7'd0, ready}, 8'd1);
    chk("cfg_err_valid", {7'd0, pkt_valid}, 8'd0);
    tick();
    chk("cfg_err_clear", {7'd0, cfg_err}, 8'd0);
    chk("cfg_err_still_idle", {7'd0, ready}, 8'd1);
    start = 1'b1; dest = 2'd0; len = 6'd0;
    tick();
    start = 1'b0;
    chk("cfg_err_len0", {7'd0, cfg_err}, 8'd1);
    chk("cfg_err_len0_valid", {7'd0, pkt_valid}, 8'd0);
    $display("illegal starts checked");
    tick();

    // Busy stall on second payload beat (beat index 2) for 3 cycles.
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3; pl[3] = 8'hD4;
    run_pkt(2'd2, 6'd4, 8'h12, 8'h16, 2, 3, 16);

    // Maximum length.
    for (int i = 0; i < 63; i++) pl[i] = 8'(i);
    run_pkt(2'd0, 6'd63, 8'hFC, 8'hC3, -1, 0, 131);

    // Reset during payload of a len=10 packet.
    start = 1'b1; dest = 2'd2; len = 6'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pl_valid = 1'b1; pl_data = 8'(8'h40 + i);
      tick();
    end
    pl_valid = 1'b0;
    tick(); tick();
    chk("abort_pld_data", pkt_data, 8'h41);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", {7'd0, pkt_valid}, 8'd0);
    chk("abort_ready", {7'd0, ready}, 8'd1);
    chk("abort_data", pkt_data, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    tick();
    chk("abort_no_done", {7'd0, done}, 8'd0);
    $display("reset abort checked");

    pl[0] = 8'h5A; pl[1] = 8'hA5;
    run_pkt(2'd1, 6'd2, 8'h09, 8'hF6, -1, 0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
